// File: rtl/hardened_multi_operand_adder.sv
// Two-stage, valid/ready pipelined three-operand adder with a redundant check path.
// Stage 1 holds a carry-save reduction of a, b and c plus a shadow copy of the raw
// operands. Stage 2 holds the carry-propagate result and an independent direct sum.
// A disagreement sends the block into a sticky FAULT state. Leaving FAULT needs
// fault_clr. While in FAULT the pipeline is flushed and the handshakes are blocked.
module hardened_multi_operand_adder #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic [1:0]       cout,
  input  logic             inj_fault,
  output logic             fault,
  input  logic             fault_clr,
  output logic [CNT_W-1:0] out_count
);

  // The result is two bits wider than an operand. That is enough for a + b + c.
  localparam int unsigned RW = WIDTH + 2;

  typedef enum logic {
    NORMAL = 1'b0,
    FAULT  = 1'b1
  } state_e;

  state_e           state_q;
  logic             rdy_en_q;

  logic             s1_valid_q, s1_valid_d;
  logic [RW-1:0]    s1_ps_q;
  logic [RW-1:0]    s1_sc_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q, s1_c_q;

  logic             s2_valid_q, s2_valid_d;
  logic [RW-1:0]    s2_pri_q;
  logic [RW-1:0]    s2_chk_q;

  logic [CNT_W-1:0] cnt_q;

  logic [RW-1:0]    a_x, b_x, c_x;
  logic [RW-1:0]    csa_ps, csa_sc, ps_load;
  logic [RW-1:0]    pri_sum, chk_sum;
  logic             is_normal, s2_free, s2_load, in_fire, out_fire;
  logic             load_mismatch, held_mismatch, trip;

  // Carry-save reduction of the live operands. The fault injector flips only
  // the primary partial-sum bit. The shadow copy is not affected.
  always_comb begin
    a_x     = {2'b00, a};
    b_x     = {2'b00, b};
    c_x     = {2'b00, c};
    csa_ps  = a_x ^ b_x ^ c_x;
    csa_sc  = ((a_x & b_x) | (a_x & c_x) | (b_x & c_x)) << 1;
    ps_load = csa_ps ^ {{(RW-1){1'b0}}, inj_fault};
  end

  // Primary result: carry-propagate add of the stored vectors.
  // Check result: direct add of the stored shadow operands.
  always_comb begin
    pri_sum = s1_ps_q + s1_sc_q;
    chk_sum = {2'b00, s1_a_q} + {2'b00, s1_b_q} + {2'b00, s1_c_q};
  end

  // Handshake and advance conditions.
  // Each stage moves forward when the stage after it is empty, or is being
  // emptied in the same cycle.
  always_comb begin
    is_normal     = (state_q == NORMAL);
    out_valid     = s2_valid_q && is_normal;
    out_fire      = out_valid && out_ready;
    s2_free       = !s2_valid_q || out_ready;
    s2_load       = is_normal && s1_valid_q && s2_free;
    in_ready      = rdy_en_q && is_normal && (!s1_valid_q || s2_free);
    in_fire       = in_valid && in_ready;
    load_mismatch = s2_load && (pri_sum != chk_sum);
    // A held result that disagrees with its check copy has been corrupted in place.
    held_mismatch = is_normal && s2_valid_q && (s2_pri_q != s2_chk_q);
    trip          = load_mismatch || held_mismatch;
  end

  // Next value of each stage's valid bit. A fault flushes both stages.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (!is_normal || trip) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (in_fire)       s1_valid_d = 1'b1;
      else if (s2_load)  s1_valid_d = 1'b0;
      if (s2_load)       s2_valid_d = 1'b1;
      else if (out_fire) s2_valid_d = 1'b0;
    end
  end

  // Fault FSM. A mismatch takes priority over fault_clr.
  // fault_clr has an effect only while the block is in FAULT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= NORMAL;
    end else begin
      unique case (state_q)
        NORMAL:  if (trip)      state_q <= FAULT;
        FAULT:   if (fault_clr) state_q <= NORMAL;
        default:                state_q <= NORMAL;
      endcase
    end
  end

  // After reset is released, hold in_ready low until the first clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en_q <= 1'b0;
    else        rdy_en_q <= 1'b1;
  end

  // Pipeline registers.
  // NOTE: the data registers are reset as well as the valid bits. This keeps
  // sum and cout at zero during reset instead of leaving a stale result visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_ps_q    <= '0;
      s1_sc_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_c_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_pri_q   <= '0;
      s2_chk_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (in_fire) begin
        s1_ps_q <= ps_load;
        s1_sc_q <= csa_sc;
        s1_a_q  <= a;
        s1_b_q  <= b;
        s1_c_q  <= c;
      end
      if (s2_load) begin
        s2_pri_q <= pri_sum;
        s2_chk_q <= chk_sum;
      end
    end
  end

  // Count completed output handshakes. The counter wraps naturally at CNT_W bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cnt_q <= '0;
    else if (out_fire) cnt_q <= cnt_q + 1'b1;
  end

  assign sum       = s2_pri_q[WIDTH-1:0];
  assign cout      = s2_pri_q[RW-1:WIDTH];
  assign fault     = (state_q == FAULT);
  assign out_count = cnt_q;

endmodule

// File: doc/hardened_multi_operand_adder.md
HARDENED_MULTI_OPERAND_ADDER -- requirements
Module: hardened_multi_operand_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits (legal 2..32).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the transaction counter width.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all flops rise-edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit, operand set offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit, block accepts operands this cycle.
REQ-007 The block SHALL have ports a, b, c, input, WIDTH bits each, unsigned operands.
REQ-008 The block SHALL have port out_valid, output, 1 bit, result valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit, consumer takes result.
REQ-010 The block SHALL have port sum, output, WIDTH bits, low bits of a+b+c.
REQ-011 The block SHALL have port cout, output, 2 bits, bits [WIDTH+1:WIDTH] of a+b+c.
REQ-012 The block SHALL have port inj_fault, input, 1 bit, test-only: flips bit 0 of the stage-1 partial-sum register on its next load.
REQ-013 The block SHALL have port fault, output, 1 bit, sticky redundancy-mismatch flag.
REQ-014 The block SHALL have port fault_clr, input, 1 bit, clears fault state.
REQ-015 The block SHALL have port out_count, output, CNT_W bits, completed output handshakes.

Function
REQ-016 Input handshake SHALL complete when in_valid && in_ready; output handshake SHALL complete when out_valid && out_ready.
REQ-017 Stage 1 SHALL register a carry-save reduction of a,b,c (partial-sum and shifted-carry vectors, WIDTH+2 bits) plus a shadow copy of raw a,b,c.
REQ-018 Stage 2 SHALL register the carry-propagate sum of the stage-1 vectors as the primary result and the direct sum of the shadow operands as the check result, both WIDTH+2 bits.
REQ-019 {cout,sum} SHALL equal the stage-2 primary result; latency SHALL be 2 cycles from input handshake to out_valid when unstalled.
REQ-020 Each stage SHALL advance when its downstream stage is empty or is being emptied in the same cycle; throughput SHALL be one result per cycle with out_ready held high.
REQ-021 in_ready SHALL be 1 when in NORMAL and stage 1 is empty or advancing; out_valid SHALL stay high and {cout,sum} stable while out_ready=0.
REQ-022 FSM SHALL have states NORMAL and FAULT; NORMAL->FAULT when stage 2 loads with primary != check.
REQ-023 In FAULT: fault=1, in_ready=0, out_valid=0, both pipeline stages invalidated, out_count held.
REQ-024 FAULT->NORMAL SHALL occur on the cycle after fault_clr=1 is sampled; fault_clr in NORMAL SHALL have no effect.
REQ-025 A mismatch and fault_clr sampled in the same cycle SHALL leave the block in FAULT.
REQ-026 out_count SHALL increment by 1 per output handshake and wrap from all-ones to 0.
REQ-027 inj_fault SHALL affect only the primary path, never the shadow path, and only on a stage-1 load.

Reset
REQ-028 While rst_n=0: state NORMAL, both stage valid bits 0, in_ready=0, out_valid=0, sum=0, cout=0, fault=0, out_count=0.
REQ-029 in_ready SHALL rise on the first clk edge after rst_n deasserts; reset asserted mid-transaction SHALL discard all in-flight data immediately.

Verification (WIDTH=4)
REQ-030 a=0001,b=0010,c=0000, out_ready=1 -> 2 cycles later out_valid=1, cout=00, sum=0011, out_count=1.
REQ-031 Back-to-back a=b=1111,c=0001 then a=b=c=1111 -> consecutive cycles cout=01 sum=1111, then cout=10 sum=1101.
REQ-032 a=0111,b=0001,c=0001 with out_ready=0 for 5 cycles -> out_valid held, cout=00 sum=1001 stable, in_ready drops once both stages full.
REQ-033 inj_fault=1 on an accepted input -> 2 cycles later fault=1, in_ready=0, out_valid=0; fault_clr pulse -> NORMAL next cycle, next input computes correctly.
REQ-034 CNT_W=2, 5 output handshakes -> out_count sequence 1,2,3,0,1.
REQ-035 rst_n pulsed low with both stages full -> out_valid=0 and out_count=0 immediately, no stale result after release.
